// File: rtl/onehot_to_bin_dec_if.sv
// rtl/onehot_to_bin_dec_if.sv - stream interface for the one-hot to binary decoder
// Input beat (valid_i/one_hot_i/ready_o), output beat (valid_o/bin_o/err_o/ready_i) and error count.
interface onehot_to_bin_dec_if #(
   parameter int ONE_HOT_W = 16,
   parameter int BIN_W     = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 valid_i;
   logic [ONE_HOT_W-1:0] one_hot_i;
   logic                 ready_o;
   logic                 valid_o;
   logic [BIN_W-1:0]     bin_o;
   logic                 err_o;
   logic                 ready_i;
   logic [ERR_CNT_W-1:0] err_cnt_o;

   modport master (
      output valid_i, one_hot_i, ready_i,
      input  ready_o, valid_o, bin_o, err_o, err_cnt_o
   );

   modport slave (
      input  valid_i, one_hot_i, ready_i,
      output ready_o, valid_o, bin_o, err_o, err_cnt_o
   );
endinterface

// File: rtl/onehot_to_bin_dec.sv
// rtl/onehot_to_bin_dec.sv - one-hot to binary index decoder with one registered stream stage
// Malformed inputs (zero-hot or multi-hot) raise err_o and bump a saturating counter.
module onehot_to_bin_dec #(
   parameter int ONE_HOT_W = 16,
   parameter int BIN_W     = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   onehot_to_bin_dec_if.slave  bus
);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic                 ready;
   logic                 accept;
   logic                 found;
   logic [BIN_W-1:0]     dec_bin;
   logic                 dec_err;
   logic                 valid_q;
   logic [BIN_W-1:0]     bin_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] cnt_q;

   assign ready  = !valid_q || bus.ready_i;
   assign accept = bus.valid_i && ready;

   // Lowest set bit wins; a non-zero x & (x-1) means more than one bit is set.
   always_comb begin
      dec_bin = '0;
      found   = 1'b0;
      for (int i = 0; i < ONE_HOT_W; i++) begin
         if (bus.one_hot_i[i] && !found) begin
            dec_bin = BIN_W'(i);
            found   = 1'b1;
         end
      end
      dec_err = !found ||
                ((bus.one_hot_i & (bus.one_hot_i - ONE_HOT_W'(1))) != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            valid_q <= 1'b1;
            bin_q   <= dec_bin;
            err_q   <= dec_err;
            if (dec_err && (cnt_q != CNT_MAX)) begin
               cnt_q <= cnt_q + ERR_CNT_W'(1);
            end
         end else if (valid_q && bus.ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.ready_o   = ready;
   assign bus.valid_o   = valid_q;
   assign bus.bin_o     = bin_q;
   assign bus.err_o     = err_q;
   assign bus.err_cnt_o = cnt_q;
endmodule
